// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the round-robin stream mux.
// Holds default sizes and the modulo-N pointer step used by the arbiter.
package mux_arb_pkg;

  localparam int MUX_ARB_DEFAULT_N = 4;
  localparam int MUX_ARB_DEFAULT_W = 1;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/mux_arb_n_rr_arbiter.sv
// Round-robin arbiter: owns the priority pointer, grants the first
// requester at or after ptr. Ports: clk, reset_n, req, update -> gnt_*.
module rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N = MUX_ARB_DEFAULT_N,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     req,
  input  logic             update,
  output logic [N-1:0]     gnt_onehot,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any_gnt
);

  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_d;

  always_comb begin : search_p
    int idx;
    idx        = 0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any_gnt    = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!any_gnt && req[idx]) begin
        any_gnt         = 1'b1;
        gnt_idx         = SEL_W'(idx);
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (update) ptr_d = SEL_W'(rr_next(int'(gnt_idx), N));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel registered stream mux with round-robin arbitration and
// valid/ready on both sides; out_sel tags the source channel.
// Ports: in_valid/in_data/in_ready, out_valid/out_data/out_sel/out_ready.
// MUX_ARB_FORCE_EN adds force_en/force_sel for a forced grant.
module mux_arb_n
  import mux_arb_pkg::*;
#(
  parameter int N = MUX_ARB_DEFAULT_N,
  parameter int W = MUX_ARB_DEFAULT_W,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset_n,
`ifdef MUX_ARB_FORCE_EN
  input  logic             force_en,
  input  logic [SEL_W-1:0] force_sel,
`endif
  input  logic [N-1:0]     in_valid,
  input  logic [N*W-1:0]   in_data,
  output logic [N-1:0]     in_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_sel
);

  logic [N-1:0]     rr_onehot;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_any;
  logic [N-1:0]     gnt_onehot;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             load;
  logic             xfer;
  logic             upd;
  logic [W-1:0]     mux_data;

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;

  rr_arbiter #(.N(N)) u_arb (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (in_valid),
    .update     (upd),
    .gnt_onehot (rr_onehot),
    .gnt_idx    (rr_idx),
    .any_gnt    (rr_any)
  );

  always_comb begin
    gnt_onehot = rr_onehot;
    gnt_idx    = rr_idx;
    gnt_any    = rr_any;
`ifdef MUX_ARB_FORCE_EN
    // Out-of-range or idle forced channel yields no grant.
    if (force_en) begin
      gnt_onehot = '0;
      for (int i = 0; i < N; i++)
        if (int'(force_sel) == i && in_valid[i])
          gnt_onehot[i] = 1'b1;
      gnt_idx = force_sel;
      gnt_any = |gnt_onehot;
    end
`endif
  end

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < N; i++)
      mux_data = mux_data
               | ({W{gnt_onehot[i]}} & in_data[i*W +: W]);
  end

  assign load = !out_valid_q || out_ready;
  assign xfer = load && gnt_any;

  // Forced grants leave the round-robin order untouched.
  always_comb begin
    upd = xfer;
`ifdef MUX_ARB_FORCE_EN
    if (force_en) upd = 1'b0;
`endif
  end

  assign in_ready = (load && reset_n) ? gnt_onehot : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_sel_d   = gnt_idx;
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Bench for mux_arb_n: N=4/W=8 and N=3/W=8 instances, vector tables
// with a scoreboard queue of expected {sel, data} output words.
module tb_mux_arb_n;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic        ordy;
    logic        fe;
    logic [1:0]  fs;
    logic [3:0]  exp_rdy;
  } vec_t;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]  v4;
  logic [31:0] d4;
  logic [3:0]  r4;
  logic        ordy4, ov4, fe4;
  logic [7:0]  od4;
  logic [1:0]  os4, fs4;

  logic [2:0]  v3;
  logic [23:0] d3;
  logic [2:0]  r3;
  logic        ordy3, ov3, fe3;
  logic [7:0]  od3;
  logic [1:0]  os3, fs3;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  vec_t tbl[$];
  vec_t tbl3[$];

  mux_arb_n #(.N(4), .W(8)) u4 (
    .clk       (clk),
    .reset_n   (rst_n),
`ifdef MUX_ARB_FORCE_EN
    .force_en  (fe4),
    .force_sel (fs4),
`endif
    .in_valid  (v4),
    .in_data   (d4),
    .in_ready  (r4),
    .out_ready (ordy4),
    .out_valid (ov4),
    .out_data  (od4),
    .out_sel   (os4)
  );

  mux_arb_n #(.N(3), .W(8)) u3 (
    .clk       (clk),
    .reset_n   (rst_n),
`ifdef MUX_ARB_FORCE_EN
    .force_en  (fe3),
    .force_sel (fs3),
`endif
    .in_valid  (v3),
    .in_data   (d3),
    .in_ready  (r3),
    .out_ready (ordy3),
    .out_valid (ov3),
    .out_data  (od3),
    .out_sel   (os3)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] v,
                              input logic [31:0] d,
                              input logic ordy,
                              input logic fe,
                              input logic [1:0] fs,
                              input logic [3:0] er);
    vec_t r;
    r.v = v; r.d = d; r.ordy = ordy;
    r.fe = fe; r.fs = fs; r.exp_rdy = er;
    return r;
  endfunction

  task automatic apply(input vec_t r, input bit n3);
    logic [3:0] rdy;
    logic       ov;
    logic [7:0] od;
    logic [1:0] os;
    exp_t       e;
    @(negedge clk);
    if (n3) begin
      v3 = r.v[2:0]; d3 = r.d[23:0]; ordy3 = r.ordy;
    end else begin
      v4 = r.v; d4 = r.d; ordy4 = r.ordy;
      fe4 = r.fe; fs4 = r.fs;
    end
    #1;
    if (n3) begin
      rdy = {1'b0, r3}; ov = ov3; od = od3; os = os3;
    end else begin
      rdy = r4; ov = ov4; od = od4; os = os4;
    end
    chk("in_ready", 32'(rdy), 32'(r.exp_rdy));
    chk("out_valid", 32'(ov), 32'(sb.size() != 0));
    if (ov && sb.size() != 0) begin
      e = r.ordy ? sb.pop_front() : sb[0];
      chk("out_sel", 32'(os), 32'(e.sel));
      chk("out_data", 32'(od), 32'(e.data));
    end
    for (int g = 0; g < 4; g++)
      if (r.exp_rdy[g]) begin
        e.sel  = 2'(g);
        e.data = r.d[g*8 +: 8];
        sb.push_back(e);
      end
  endtask

  localparam logic [31:0] DALL = 32'h13121110;
  localparam logic [31:0] DA5  = 32'h00A50000;
  localparam logic [31:0] D3   = 32'h00C2B1A0;

  initial begin
    // fairness from ptr 0
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(4'hF, DALL, 1, 0, 0, 4'(1 << (k % 4))));
    tbl.push_back(mk(4'h0, DALL, 1, 0, 0, 4'h0));
    // single channel 2, ptr -> 3
    tbl.push_back(mk(4'h4, DA5, 1, 0, 0, 4'h4));
    tbl.push_back(mk(4'h0, DA5, 1, 0, 0, 4'h0));
    // backpressure: grant ch3, stall 3 cycles, resume at 0
    tbl.push_back(mk(4'hF, DALL, 0, 0, 0, 4'h8));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(4'hF, DALL, 0, 0, 0, 4'h0));
    tbl.push_back(mk(4'hF, DALL, 1, 0, 0, 4'h1));
    tbl.push_back(mk(4'hF, DALL, 1, 0, 0, 4'h2));
    tbl.push_back(mk(4'h0, DALL, 1, 0, 0, 4'h0));
    tbl.push_back(mk(4'h0, DALL, 1, 0, 0, 4'h0));
`ifdef MUX_ARB_FORCE_EN
    // ptr is 2 here; forced grants must not move it
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(4'hF, DALL, 1, 1, 3, 4'h8));
    tbl.push_back(mk(4'hD, DALL, 1, 1, 1, 4'h0));
    tbl.push_back(mk(4'hF, DALL, 1, 0, 0, 4'h4));
    tbl.push_back(mk(4'h0, DALL, 1, 0, 0, 4'h0));
    tbl.push_back(mk(4'h0, DALL, 1, 0, 0, 4'h0));
`endif
    // N=3 wrap: sel 2, 0, 2
    tbl3.push_back(mk(4'h4, D3, 1, 0, 0, 4'h4));
    tbl3.push_back(mk(4'h5, D3, 1, 0, 0, 4'h1));
    tbl3.push_back(mk(4'h5, D3, 1, 0, 0, 4'h4));
    tbl3.push_back(mk(4'h0, D3, 1, 0, 0, 4'h0));
    tbl3.push_back(mk(4'h0, D3, 1, 0, 0, 4'h0));

    rst_n = 1'b0;
    v4 = 4'($urandom); d4 = $urandom; ordy4 = 1'($urandom);
    fe4 = 1'b0; fs4 = 2'($urandom);
    v3 = 3'($urandom); d3 = 24'($urandom); ordy3 = 1'($urandom);
    fe3 = 1'b0; fs3 = 2'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(ov4), 0);
    chk("rst_out_data", 32'(od4), 0);
    chk("rst_out_sel", 32'(os4), 0);
    chk("rst_in_ready", 32'(r4), 0);
    chk("rst_in_ready3", 32'(r3), 0);
    chk("rst_out_valid3", 32'(ov3), 0);
    v4 = '0; d4 = '0; ordy4 = 1'b1;
    v3 = '0; d3 = '0; ordy3 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i], 1'b0);
    chk("sb_drain4", 32'(sb.size()), 0);
    foreach (tbl3[i]) apply(tbl3[i], 1'b1);
    chk("sb_drain3", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
